column_prefetcher: RTL and testbench

Parametrised multi-channel column-index prefetcher. It walks per-channel address ranges in a shared single-port synchronous ROM and fills one internal FIFO per channel with the fetched column IDs. Downstream sparse-MAC lanes pop those FIFOs. It sits between the column-index ROM and the per-channel multiply pipelines. It supports run-time start addresses and lengths, credit-based overflow protection that accounts for the ROM read latency, and per-channel completion flags.

---
 rtl/column_prefetcher.sv | 246 ++++++++++++++++++++++++
 tb/tb_column_prefetcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_prefetcher.sv
// column_prefetcher
//
// Multi-channel column-index prefetcher. On a start pulse each channel latches a
// ROM start address and a word count. The block then walks those ranges through a
// shared single-port ROM (one read per cycle at most) and fills one FWFT FIFO per
// channel. Overflow is prevented by a credit check: FIFO occupancy plus reads
// still in flight must stay below FIFO_DEPTH.
//
// Optional feature macro: COLUMN_PREFETCH_SKIP_EN
//   defined   : work-conserving arbiter (first eligible channel at/after pointer)
//   undefined : strict round-robin, pointer steps every RUN cycle
//
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, latches base/len; ignored while busy
//   base, len : per-channel start address / word count, ADDR_W bits per channel
//   rom_en    : registered ROM read enable
//   rom_addr  : registered ROM address
//   rom_data  : ROM word, valid the cycle after rom_en
//   read      : per-channel pop (ignored when that FIFO is empty)
//   out       : per-channel FIFO head, DATA_W bits per channel (0 when empty)
//   empty     : per-channel FIFO empty
//   done      : channel has issued and written all of its words
//   busy      : high from the cycle after an accepted start until drain completes

module column_prefetcher #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CH_LOG     = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_LOG   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CHANNELS*ADDR_W-1:0] base,
  input  logic [CHANNELS*ADDR_W-1:0] len,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  input  logic [CHANNELS-1:0]        read,
  output logic [CHANNELS*DATA_W-1:0] out,
  output logic [CHANNELS-1:0]        empty,
  output logic [CHANNELS-1:0]        done,
  output logic                       busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [FIFO_LOG+1:0] DepthW = (FIFO_LOG+2)'(FIFO_DEPTH);

  state_e state_q, state_d;

  // Per-channel walk state
  logic [ADDR_W-1:0] addr_q [CHANNELS];
  logic [ADDR_W-1:0] rem_q  [CHANNELS];
  logic [CHANNELS-1:0] done_q;
  logic [CH_LOG-1:0]   ptr_q;

  // Read pipeline: stage 1 is the cycle rom_en is high, stage 2 is write-back
  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [CH_LOG-1:0] s1_tag_q;
  logic              s1_last_q;
  logic              wb_valid_q;
  logic [CH_LOG-1:0] wb_tag_q;
  logic              wb_last_q;

  // Channel FIFOs
  logic [DATA_W-1:0]   mem_q    [CHANNELS][FIFO_DEPTH];
  logic [FIFO_LOG-1:0] rd_ptr_q [CHANNELS];
  logic [FIFO_LOG-1:0] wr_ptr_q [CHANNELS];
  logic [FIFO_LOG:0]   occ_q    [CHANNELS];

  logic [1:0]          pend [CHANNELS];
  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] fifo_wr;
  logic [CHANNELS-1:0] fifo_pop;
  logic                arb_hit;
  logic [CH_LOG-1:0]   arb_pick;
  logic [CH_LOG-1:0]   ptr_next;
  logic                issue;
  logic                rem_clear;
  logic                any_len;

  function automatic logic [CH_LOG-1:0] ch_inc(input logic [CH_LOG-1:0] ch);
    if (32'(ch) == CHANNELS - 1) return '0;
    return ch + CH_LOG'(1);
  endfunction

  // Credit: a channel may only issue while its occupancy plus its reads still in
  // the two-stage pipeline leaves room, so a write can never find the FIFO full.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pend[c] = {1'b0, rom_en_q && (s1_tag_q == CH_LOG'(c))}
              + {1'b0, wb_valid_q && (wb_tag_q == CH_LOG'(c))};
      elig[c] = (rem_q[c] != '0) &&
                (({1'b0, occ_q[c]} + {{FIFO_LOG{1'b0}}, pend[c]}) < DepthW);
    end
  end

`ifdef COLUMN_PREFETCH_SKIP_EN
  int unsigned idx;

  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = ptr_q;
    idx      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (32'(ptr_q) + 32'(k)) % CHANNELS;
      if (!arb_hit && elig[CH_LOG'(idx)]) begin
        arb_hit  = 1'b1;
        arb_pick = CH_LOG'(idx);
      end
    end
    ptr_next = arb_hit ? ch_inc(arb_pick) : ptr_q;
  end
`else
  // Strict round-robin: the slot belongs to the pointed channel or goes idle.
  always_comb begin
    arb_hit  = elig[ptr_q];
    arb_pick = ptr_q;
    ptr_next = ch_inc(ptr_q);
  end
`endif

  assign issue = (state_q == StRun) && arb_hit;

  // True when no channel will have words left after this cycle's issue.
  always_comb begin
    rem_clear = 1'b1;
    any_len   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((rem_q[c] != '0) &&
          !(issue && (arb_pick == CH_LOG'(c)) && (rem_q[c] == ADDR_W'(1)))) begin
        rem_clear = 1'b0;
      end
      if (len[c*ADDR_W +: ADDR_W] != '0) any_len = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && any_len) state_d = StRun;
      StRun:   if (rem_clear) state_d = StDrain;
      StDrain: if (!rom_en_q && !wb_valid_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      fifo_wr[c]  = wb_valid_q && (wb_tag_q == CH_LOG'(c));
      fifo_pop[c] = read[c] && (occ_q[c] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        addr_q[c]   <= '0;
        rem_q[c]    <= '0;
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
      done_q     <= '0;
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      s1_tag_q   <= '0;
      s1_last_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_last_q  <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        for (int c = 0; c < CHANNELS; c++) begin
          addr_q[c] <= base[c*ADDR_W +: ADDR_W];
          rem_q[c]  <= len[c*ADDR_W +: ADDR_W];
          done_q[c] <= (len[c*ADDR_W +: ADDR_W] == '0);
        end
      end else if (issue) begin
        addr_q[arb_pick] <= addr_q[arb_pick] + ADDR_W'(1);
        rem_q[arb_pick]  <= rem_q[arb_pick] - ADDR_W'(1);
      end

      if (state_q == StRun) ptr_q <= ptr_next;

      rom_en_q <= issue;
      if (issue) begin
        rom_addr_q <= addr_q[arb_pick];
        s1_tag_q   <= arb_pick;
        s1_last_q  <= (rem_q[arb_pick] == ADDR_W'(1));
      end

      wb_valid_q <= rom_en_q;
      wb_tag_q   <= s1_tag_q;
      wb_last_q  <= s1_last_q;
      if (wb_valid_q && wb_last_q) done_q[wb_tag_q] <= 1'b1;

      for (int c = 0; c < CHANNELS; c++) begin
        if (fifo_wr[c])  wr_ptr_q[c] <= wr_ptr_q[c] + FIFO_LOG'(1);
        if (fifo_pop[c]) rd_ptr_q[c] <= rd_ptr_q[c] + FIFO_LOG'(1);
        if (fifo_wr[c] && !fifo_pop[c]) begin
          occ_q[c] <= occ_q[c] + (FIFO_LOG+1)'(1);
        end else if (!fifo_wr[c] && fifo_pop[c]) begin
          occ_q[c] <= occ_q[c] - (FIFO_LOG+1)'(1);
        end
      end
    end
  end

  // FIFO storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && wb_valid_q) mem_q[wb_tag_q][wr_ptr_q[wb_tag_q]] <= rom_data;
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;

  // done rises already during the write-back cycle of the channel's last word.
  always_comb begin
    out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c] = (occ_q[c] == '0);
      if (occ_q[c] != '0) out[c*DATA_W +: DATA_W] = mem_q[c][rd_ptr_q[c]];
      done[c] = done_q[c] | (wb_valid_q && wb_last_q && (wb_tag_q == CH_LOG'(c)));
    end
  end

endmodule

// File: tb/tb_column_prefetcher.sv
// Testbench for column_prefetcher: ROM model, per-channel expected-word queues
// filled from base/len on each accepted start, checks on every pop and at the end
// of each run.

module tb_column_prefetcher;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int AW = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CH*AW-1:0]  base;
  logic [CH*AW-1:0]  len;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic [CH-1:0]     read;
  logic [CH*DW-1:0]  dout;
  logic [CH-1:0]     empty;
  logic [CH-1:0]     done;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] exp_q [CH][$];
  logic [AW-1:0] addr_log[$];
  int            en_cyc[$];
  bit            rd_random;
  logic [CH-1:0] rd_fixed;

  column_prefetcher #(
    .CHANNELS(4), .CH_LOG(2), .DATA_W(16), .ADDR_W(13), .FIFO_DEPTH(16), .FIFO_LOG(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .read(read), .out(dout), .empty(empty), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return (DW'(a) * DW'(40503)) ^ DW'(16'h5a3c);
  endfunction

  // Synchronous ROM: data valid the cycle after rom_en.
  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  always @(posedge clk) begin
    if (!rst && rom_en) begin
      addr_log.push_back(rom_addr);
      en_cyc.push_back(cyc);
    end
  end

  function automatic logic [CH*AW-1:0] pack(input int a0, input int a1, input int a2,
                                             input int a3);
    logic [CH*AW-1:0] v;
    v[0*AW +: AW] = AW'(a0);
    v[1*AW +: AW] = AW'(a1);
    v[2*AW +: AW] = AW'(a2);
    v[3*AW +: AW] = AW'(a3);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  // One clock: choose reads, check the heads that will be popped, then advance.
  task automatic tick();
    logic [CH-1:0] r;
    r = rd_random ? CH'($urandom) : rd_fixed;
    read = r;
    for (int c = 0; c < CH; c++) begin
      if (r[c] && !empty[c]) begin
        if (exp_q[c].size() == 0) begin
          tests++;
          fails++;
          $error("FAIL pop_extra_ch%0d: observed %0h expected no word", c, dout[c*DW +: DW]);
        end else begin
          check($sformatf("pop_ch%0d", c), 64'(dout[c*DW +: DW]), 64'(exp_q[c].pop_front()));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input logic [CH*AW-1:0] b, input logic [CH*AW-1:0] l,
                          input bit accept);
    base  = b;
    len   = l;
    start = 1'b1;
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < int'(l[c*AW +: AW]); k++) begin
          exp_q[c].push_back(rom_fn(AW'(int'(b[c*AW +: AW]) + k)));
        end
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int bound);
    int n;
    if (!rd_random) rd_fixed = '1;
    n = 0;
    while (busy && n < bound) begin tick(); n++; end
    if (busy) timeout({tag, "_busy"});
    rd_random = 0;
    rd_fixed  = '1;
    n = 0;
    while (empty != '1 && n < bound) begin tick(); n++; end
    if (empty != '1) timeout({tag, "_drain"});
    rd_fixed = '0;
    check({tag, "_done"}, 64'(done), 64'(4'hF));
    check({tag, "_empty"}, 64'(empty), 64'(4'hF));
    for (int c = 0; c < CH; c++) check($sformatf("%s_left_ch%0d", tag, c), 64'(exp_q[c].size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [CH*AW-1:0] rb, rl;
    logic [AW-1:0]    wrap_exp[4];
    int               gap, found;

    rst = 1'b1; start = 1'b0; base = '0; len = '0; read = '0;
    rd_random = 0; rd_fixed = '0;
    @(negedge clk);
    tick();
    tick();
    check("rst_rom_en", 64'(rom_en), 0);
    check("rst_rom_addr", 64'(rom_addr), 0);
    check("rst_empty", 64'(empty), 64'(4'hF));
    check("rst_out", 64'(dout), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    tick();

    // Four channels, three words each, reads held high.
    rd_fixed = '1;
    addr_log.delete();
    do_start(pack(0, 100, 200, 300), pack(3, 3, 3, 3), 1);
    check("a_busy", 64'(busy), 1);
    check("a_first_en", 64'(rom_en), 0);
    finish_run("a", 200);
    check("a_issues", 64'(addr_log.size()), 12);

    // Single channel: issue spacing depends on the arbiter.
    rd_fixed = '0;
    addr_log.delete();
    en_cyc.delete();
    do_start(pack(500, 0, 0, 0), pack(5, 0, 0, 0), 1);
    check("b_done_early", 64'(done), 64'(4'b1110));
    repeat (40) tick();
    check("b_issues", 64'(en_cyc.size()), 5);
    gap = (en_cyc.size() >= 5) ? en_cyc[4] - en_cyc[0] : -1;
`ifdef COLUMN_PREFETCH_SKIP_EN
    check("b_gap", 64'(gap), 4);
`else
    check("b_gap", 64'(gap), 16);
`endif
    finish_run("b", 200);

    // Credit: FIFO 0 fills to exactly FIFO_DEPTH, one pop releases one issue.
    addr_log.delete();
    do_start(pack(1000, 0, 0, 0), pack(40, 0, 0, 0), 1);
    repeat (200) tick();
    check("c_full_issues", 64'(addr_log.size()), 16);
    check("c_busy", 64'(busy), 1);
    check("c_done0", 64'(done[0]), 0);
    rd_fixed = 4'b0001;
    tick();
    rd_fixed = '0;
    repeat (40) tick();
    check("c_one_more", 64'(addr_log.size()), 17);
    finish_run("c", 1000);
    check("c_total", 64'(addr_log.size()), 40);

    // Address wrap.
    addr_log.delete();
    wrap_exp[0] = 13'd8190; wrap_exp[1] = 13'd8191; wrap_exp[2] = 13'd0; wrap_exp[3] = 13'd1;
    do_start(pack(0, 8190, 0, 0), pack(0, 4, 0, 0), 1);
    finish_run("d", 200);
    check("d_issues", 64'(addr_log.size()), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      check($sformatf("d_addr%0d", i), 64'(addr_log[i]), 64'(wrap_exp[i]));
    end

    // Reset during the write-back cycle of a channel 2 read.
    rd_fixed = '0;
    do_start(pack(10, 20, 30, 40), pack(4, 4, 4, 4), 1);
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      if (rom_en && rom_addr >= 13'd30 && rom_addr < 13'd34) found = 1;
      else tick();
    end
    if (found == 0) timeout("e_issue_ch2");
    tick();
    rst = 1'b1;
    tick();
    check("e_empty", 64'(empty), 64'(4'hF));
    check("e_busy", 64'(busy), 0);
    check("e_rom_en", 64'(rom_en), 0);
    check("e_done", 64'(done), 0);
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    rst = 1'b0;
    tick();

    // Fresh start after reset, random reads.
    rd_random = 1;
    do_start(pack(7, 3000, 6000, 8000), pack(6, 2, 9, 4), 1);
    finish_run("f", 2000);

    // Start while busy must be ignored.
    rd_random = 1;
    do_start(pack(2000, 2100, 2200, 2300), pack(5, 5, 5, 5), 1);
    repeat (3) tick();
    do_start(pack(4000, 4100, 4200, 4300), pack(7, 7, 7, 7), 0);
    finish_run("g", 2000);

    // All lengths zero: stays idle.
    do_start('0, '0, 1);
    check("h_busy", 64'(busy), 0);
    check("h_done", 64'(done), 64'(4'hF));

    // Randomised runs.
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < CH; c++) begin
        rb[c*AW +: AW] = AW'($urandom_range(0, 8191));
        rl[c*AW +: AW] = AW'($urandom_range(0, 20));
      end
      rd_random = 1;
      do_start(rb, rl, 1);
      finish_run($sformatf("r%0d", it), 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
